// File: rtl/multi_port_fifo.sv
// Multi-lane first-word-fall-through FIFO: up to WR_PORTS pushes and
// RD_PORTS pops per cycle, synchronous flush, registered overflow and
// underflow pulses, and an exposed occupancy count.
//
// Handshake: free_o is the producer's ready. A push of wr_cnt_i entries is
// taken only if wr_cnt_i <= free_o, judged before the edge; otherwise
// nothing is written and overflow_o pulses. rd_valid_o[k] is the valid for
// read lane k. The consumer takes lanes 0..rd_cnt_i-1 at the edge by
// sampling rd_data_o in the same cycle. Asking for more entries than are
// valid, or more than RD_PORTS, pops only what is available and pulses
// underflow_o.
module multi_port_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_LEN = 4,
  parameter int WR_PORTS = 2,
  parameter int RD_PORTS = 2,
  parameter int CNT_W    = 3
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic [CNT_W-1:0]             wr_cnt_i,
  input  logic [WIDTH*WR_PORTS-1:0]    wr_data_i,
  input  logic [CNT_W-1:0]             rd_cnt_i,
  output logic [WIDTH*RD_PORTS-1:0]    rd_data_o,
  output logic [RD_PORTS-1:0]          rd_valid_o,
  output logic [ADDR_LEN:0]            count_o,
  output logic [ADDR_LEN:0]            free_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam logic [ADDR_LEN:0] DEPTH_C = (ADDR_LEN+1)'(DEPTH);

  // Storage is not reset; only the pointers and count say what is valid.
  logic [WIDTH-1:0]    mem_q [DEPTH];

  logic [ADDR_LEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_LEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_LEN:0]   cnt_q, cnt_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic                push_ok;
  logic                pop_short;
  logic [CNT_W-1:0]    rd_req;
  logic [ADDR_LEN:0]   push_n;
  logic [ADDR_LEN:0]   pop_n;
  logic [WR_PORTS-1:0] wr_en;
  logic [ADDR_LEN-1:0] wr_addr [WR_PORTS];
  logic [ADDR_LEN-1:0] rd_addr [RD_PORTS];

  // Push/pop legality, next pointers, next count and flag pulses.
  always_comb begin
    push_ok     = 1'b0;
    pop_short   = 1'b0;
    rd_req      = rd_cnt_i;
    push_n      = '0;
    pop_n       = '0;
    wr_en       = '0;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    for (int k = 0; k < WR_PORTS; k++) begin
      wr_addr[k] = wr_ptr_q + ADDR_LEN'(k);
    end

    // Space is judged on pre-edge occupancy; same-cycle pops do not help.
    push_ok = (32'(wr_cnt_i) <= WR_PORTS) &&
              (32'(wr_cnt_i) <= 32'(free_o));
    if (push_ok) begin
      push_n = (ADDR_LEN+1)'(wr_cnt_i);
    end

    // Oversized read requests clamp to the lane count and still flag.
    pop_short = 1'b0;
    if (32'(rd_cnt_i) > RD_PORTS) begin
      rd_req    = CNT_W'(RD_PORTS);
      pop_short = 1'b1;
    end
    if (32'(rd_req) > 32'(cnt_q)) begin
      pop_n     = cnt_q;
      pop_short = 1'b1;
    end else begin
      pop_n = (ADDR_LEN+1)'(rd_req);
    end

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      for (int k = 0; k < WR_PORTS; k++) begin
        wr_en[k] = push_ok && (32'(wr_cnt_i) > 32'(k));
      end
      rd_ptr_d    = rd_ptr_q + ADDR_LEN'(pop_n);
      wr_ptr_d    = wr_ptr_q + ADDR_LEN'(push_n);
      cnt_d       = cnt_q + push_n - pop_n;
      overflow_d  = !push_ok;
      underflow_d = pop_short;
    end
  end

  // Control state: pointers, occupancy and the one-cycle error pulses.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write: accepted lanes land at consecutive wrapped addresses.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < WR_PORTS; k++) begin
      if (wr_en[k]) begin
        mem_q[wr_addr[k]] <= wr_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // Fall-through read lanes and status, all from registered state.
  always_comb begin
    rd_data_o  = '0;
    rd_valid_o = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      rd_addr[k]    = rd_ptr_q + ADDR_LEN'(k);
      rd_valid_o[k] = 32'(cnt_q) > 32'(k);
      if (rd_valid_o[k]) begin
        rd_data_o[k*WIDTH +: WIDTH] = mem_q[rd_addr[k]];
      end
    end
  end

  assign count_o     = cnt_q;
  assign free_o      = DEPTH_C - cnt_q;
  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == DEPTH_C);
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_multi_port_fifo.sv
// Bench for multi_port_fifo: directed scenarios plus random traffic, all
// checked against a queue-based reference model.
module tb_multi_port_fifo;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 8;
  localparam int ADDR_LEN = 3;
  localparam int WR_PORTS = 2;
  localparam int RD_PORTS = 2;
  localparam int CNT_W    = 3;

  logic                      clk_i;
  logic                      reset_i;
  logic                      flush_i;
  logic [CNT_W-1:0]          wr_cnt_i;
  logic [WIDTH*WR_PORTS-1:0] wr_data_i;
  logic [CNT_W-1:0]          rd_cnt_i;
  logic [WIDTH*RD_PORTS-1:0] rd_data_o;
  logic [RD_PORTS-1:0]       rd_valid_o;
  logic [ADDR_LEN:0]         count_o;
  logic [ADDR_LEN:0]         free_o;
  logic                      empty_o;
  logic                      full_o;
  logic                      overflow_o;
  logic                      underflow_o;

  multi_port_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_LEN(ADDR_LEN),
    .WR_PORTS(WR_PORTS), .RD_PORTS(RD_PORTS), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .wr_cnt_i(wr_cnt_i), .wr_data_i(wr_data_i), .rd_cnt_i(rd_cnt_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .count_o(count_o),
    .free_o(free_o), .empty_o(empty_o), .full_o(full_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  // Clock and reset block.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model state.
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_ovf;
  logic             exp_unf;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    logic [WIDTH-1:0] lane;
    sz = exp_q.size();
    check("count", 32'(count_o), 32'(sz));
    check("free", 32'(free_o), 32'(DEPTH - sz));
    check("empty", 32'(empty_o), 32'(sz == 0));
    check("full", 32'(full_o), 32'(sz == DEPTH));
    check("overflow", 32'(overflow_o), 32'(exp_ovf));
    check("underflow", 32'(underflow_o), 32'(exp_unf));
    for (int k = 0; k < RD_PORTS; k++) begin
      lane = (k < sz) ? exp_q[k] : '0;
      check($sformatf("valid%0d", k), 32'(rd_valid_o[k]), 32'(k < sz));
      check($sformatf("data%0d", k), 32'(rd_data_o[k*WIDTH +: WIDTH]), 32'(lane));
    end
  endtask

  // Model of one clock edge, straight from the queue semantics.
  task automatic model_edge(input int wc, input logic [WIDTH*WR_PORTS-1:0] wd,
                            input int rc, input logic fl);
    int free_pre;
    int take;
    if (fl) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      free_pre = DEPTH - exp_q.size();
      take     = (rc > RD_PORTS) ? RD_PORTS : rc;
      exp_unf  = (rc > RD_PORTS) || (rc > exp_q.size());
      if (take > exp_q.size()) take = exp_q.size();
      repeat (take) void'(exp_q.pop_front());
      if (wc <= WR_PORTS && wc <= free_pre) begin
        for (int k = 0; k < wc; k++) exp_q.push_back(wd[k*WIDTH +: WIDTH]);
        exp_ovf = 1'b0;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  // Driver: check current outputs, apply one cycle of inputs, model the edge.
  task automatic step(input int wc, input logic [WIDTH*WR_PORTS-1:0] wd,
                      input int rc, input logic fl);
    @(negedge clk_i);
    check_outputs();
    wr_cnt_i  = CNT_W'(wc);
    wr_data_i = wd;
    rd_cnt_i  = CNT_W'(rc);
    flush_i   = fl;
    @(posedge clk_i);
    model_edge(wc, wd, rc, fl);
  endtask

  task automatic idle();
    step(0, '0, 0, 1'b0);
  endtask

  task automatic drain();
    repeat (DEPTH / RD_PORTS + 1) step(0, '0, RD_PORTS, 1'b0);
  endtask

  initial begin
    logic [7:0] v;
    reset_i   = 1'b0;
    flush_i   = 1'b0;
    wr_cnt_i  = '0;
    wr_data_i = '0;
    rd_cnt_i  = '0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_outputs();
    reset_i = 1'b1;

    // Fill 2 per cycle to full, then an over-push of one entry.
    for (int i = 0; i < 4; i++) step(2, {8'(2*i+2), 8'(2*i+1)}, 0, 1'b0);
    step(1, 16'h00aa, 0, 1'b0);
    idle();
    idle();

    // Full: pop 2 + push 2 -> push rejected; then at free=2 both apply.
    step(2, 16'hbbcc, 2, 1'b0);
    step(2, 16'h4433, 2, 1'b0);
    idle();
    drain();
    idle();

    // Wrap-around stream: 40 entries, 2 in / 2 out per cycle.
    v = 8'h00;
    step(2, {v + 8'd1, v}, 0, 1'b0);
    v = v + 8'd2;
    for (int i = 1; i < 20; i++) begin
      step(2, {v + 8'd1, v}, 2, 1'b0);
      v = v + 8'd2;
    end
    step(0, '0, 2, 1'b0);
    idle();

    // Underflow: one entry present, ask for two.
    step(1, 16'h005a, 0, 1'b0);
    step(0, '0, 2, 1'b0);
    idle();
    idle();

    // Over-lane read request clamps and flags.
    step(2, 16'h6655, 0, 1'b0);
    step(1, 16'h0077, 3, 1'b0);
    drain();

    // Flush at count 6 with push and pop in the same cycle.
    for (int i = 0; i < 3; i++) step(2, {8'(8'h80 + 2*i + 1), 8'(8'h80 + 2*i)}, 0, 1'b0);
    step(2, 16'hdead, 2, 1'b1);
    step(2, 16'h2211, 0, 1'b0);
    idle();
    drain();

    // Asynchronous reset mid-stream at count 5.
    step(2, 16'h0201, 0, 1'b0);
    step(2, 16'h0403, 0, 1'b0);
    step(1, 16'h0005, 0, 1'b0);
    @(negedge clk_i);
    check_outputs();
    wr_cnt_i = '0;
    rd_cnt_i = '0;
    #2 reset_i = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    check_outputs();
    @(negedge clk_i);
    reset_i = 1'b1;
    step(2, 16'h2211, 0, 1'b0);
    idle();

    // Random traffic with occasional flush.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3), 16'($urandom), $urandom_range(0, 3),
           ($urandom_range(0, 40) == 0));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
